// File: rtl/arbi_pkg.sv
// Shared definitions for the arbiter request issuer: default data width
// and the per-channel request state encoding.
package arbi_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } req_state_e;

endpackage

// File: rtl/arbi_req_fifo.sv
// Synchronous per-channel FIFO. Head is the word at the read pointer.
// Occupancy is a separate up/down counter (0..DEPTH). Storage is not reset.
module arbi_req_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head,
  output logic [$clog2(DEPTH):0]   cnt,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop && !empty;
  // A simultaneous pop frees the slot, so a push at full is still safe.
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q];
  assign cnt     = cnt_q;

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Word storage, written on accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/arbi_req_issuer.sv
// Two-channel request feeder for the two-requester arbiter.
// Optional grant/stall statistics: define ARBI_REQ_STATS_EN.
//
// state | meaning
// IDLE  | FIFO empty, no request
// REQ   | req_x high, head presented; retire on grant qualified by last-cycle req
// GAP   | one cycle with req_x low after a retire, lets the other channel win
module arbi_req_issuer
  import arbi_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in0_valid,
  input  logic [DATA_W-1:0]      in0_data,
  output logic                   in0_ready,
  input  logic                   in1_valid,
  input  logic [DATA_W-1:0]      in1_data,
  output logic                   in1_ready,
  output logic                   req_0,
  output logic                   req_1,
  output logic [DATA_W-1:0]      data_in0,
  output logic [DATA_W-1:0]      data_in1,
  input  logic                   grant_0,
  input  logic                   grant_1,
  output logic [$clog2(DEPTH):0] cnt0,
  output logic [$clog2(DEPTH):0] cnt1
`ifdef ARBI_REQ_STATS_EN
  ,
  output logic [15:0]            gnt_cnt0,
  output logic [15:0]            gnt_cnt1,
  output logic [15:0]            stall_cnt0,
  output logic [15:0]            stall_cnt1
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]        push, pop, full, empty, req, grant;
  logic [1:0]        req_hist_q, req_hist_d;
  logic [DATA_W-1:0] in_data [2];
  logic [DATA_W-1:0] head    [2];
  logic [CW-1:0]     cnt     [2];
  req_state_e        state_q [2];
  req_state_e        state_d [2];

  assign in_data[0] = in0_data;
  assign in_data[1] = in1_data;
  assign push       = {in1_valid && !full[1], in0_valid && !full[0]};
  assign grant      = {grant_1, grant_0};
  assign req_hist_d = req;

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    arbi_req_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push[ch]),
      .push_data (in_data[ch]),
      .pop       (pop[ch]),
      .head      (head[ch]),
      .cnt       (cnt[ch]),
      .full      (full[ch]),
      .empty     (empty[ch])
    );
  end

  assign in0_ready = !full[0];
  assign in1_ready = !full[1];
  assign req_0     = req[0];
  assign req_1     = req[1];
  assign data_in0  = empty[0] ? '0 : head[0];
  assign data_in1  = empty[1] ? '0 : head[1];
  assign cnt0      = cnt[0];
  assign cnt1      = cnt[1];

  // Channel FSMs: a grant only retires the head if req was already high
  // last cycle, since the arbiter holds grant_x after req_x drops.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      pop[i]     = 1'b0;
      req[i]     = (state_q[i] == REQ);
      unique case (state_q[i])
        IDLE: if (cnt[i] != '0) state_d[i] = REQ;
        REQ: begin
          if (grant[i] && req_hist_q[i]) begin
            pop[i]     = 1'b1;
            state_d[i] = GAP;
          end
        end
        GAP:     state_d[i] = (cnt[i] != '0) ? REQ : IDLE;
        default: state_d[i] = IDLE;
      endcase
    end
  end

  // FSM state and request history registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q[0] <= IDLE;
      state_q[1] <= IDLE;
      req_hist_q <= '0;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      req_hist_q <= req_hist_d;
    end
  end

`ifdef ARBI_REQ_STATS_EN
  logic [15:0] gnt_cnt_q   [2];
  logic [15:0] gnt_cnt_d   [2];
  logic [15:0] stall_cnt_q [2];
  logic [15:0] stall_cnt_d [2];

  // Saturating retire and stall counters.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      gnt_cnt_d[i]   = gnt_cnt_q[i];
      stall_cnt_d[i] = stall_cnt_q[i];
      if (pop[i] && (gnt_cnt_q[i] != 16'hFFFF))
        gnt_cnt_d[i] = gnt_cnt_q[i] + 16'd1;
      if (req[i] && !pop[i] && (stall_cnt_q[i] != 16'hFFFF))
        stall_cnt_d[i] = stall_cnt_q[i] + 16'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        gnt_cnt_q[i]   <= '0;
        stall_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        gnt_cnt_q[i]   <= gnt_cnt_d[i];
        stall_cnt_q[i] <= stall_cnt_d[i];
      end
    end
  end

  assign gnt_cnt0   = gnt_cnt_q[0];
  assign gnt_cnt1   = gnt_cnt_q[1];
  assign stall_cnt0 = stall_cnt_q[0];
  assign stall_cnt1 = stall_cnt_q[1];
`else
  // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_arbi_req_issuer.sv
// Self-checking bench for arbi_req_issuer with a registered, ch0-priority
// arbiter model that holds its grant while no request is present.
module tb_arbi_req_issuer;

  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in0_valid = 1'b0, in1_valid = 1'b0;
  logic [DW-1:0] in0_data = '0, in1_data = '0;
  logic          in0_ready, in1_ready;
  logic          req_0, req_1;
  logic [DW-1:0] data_in0, data_in1;
  logic          grant_0, grant_1;
  logic [CW-1:0] cnt0, cnt1;
`ifdef ARBI_REQ_STATS_EN
  logic [15:0]   gnt_cnt0, gnt_cnt1, stall_cnt0, stall_cnt1;
`endif

  arbi_req_issuer #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_ready (in1_ready),
    .req_0     (req_0),
    .req_1     (req_1),
    .data_in0  (data_in0),
    .data_in1  (data_in1),
    .grant_0   (grant_0),
    .grant_1   (grant_1),
    .cnt0      (cnt0),
    .cnt1      (cnt1)
`ifdef ARBI_REQ_STATS_EN
    ,
    .gnt_cnt0  (gnt_cnt0),
    .gnt_cnt1  (gnt_cnt1),
    .stall_cnt0(stall_cnt0),
    .stall_cnt1(stall_cnt1)
`endif
  );

  always #5 clk = ~clk;

  // Arbiter model
  logic          force_zero = 1'b0;
  logic [DW-1:0] arb_out;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_0 <= 1'b0;
      grant_1 <= 1'b0;
      arb_out <= '0;
    end else if (force_zero) begin
      grant_0 <= 1'b0;
      grant_1 <= 1'b0;
    end else if (req_0) begin
      grant_0 <= 1'b1;
      grant_1 <= 1'b0;
      arb_out <= data_in0;
    end else if (req_1) begin
      grant_0 <= 1'b0;
      grant_1 <= 1'b1;
      arb_out <= data_in1;
    end
  end

  // Delivery log: a transfer is a grant matching a request held for two cycles.
  logic [DW-1:0] log0[$], log1[$];
  int            order[$];
  logic          r0p, r1p;

  always @(negedge clk) begin
    if (!reset) begin
      r0p <= 1'b0;
      r1p <= 1'b0;
    end else begin
      if (grant_0 && req_0 && r0p) begin log0.push_back(arb_out); order.push_back(0); end
      if (grant_1 && req_1 && r1p) begin log1.push_back(arb_out); order.push_back(1); end
      r0p <= req_0;
      r1p <= req_1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    log0.delete();
    log1.delete();
    order.delete();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
    clear_logs();
  endtask

  typedef struct {
    bit            ch;
    logic [DW-1:0] data;
    logic [DW-1:0] exp_arb;
    logic [CW-1:0] exp_cnt_t1;
  } vec_t;

  vec_t tbl[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 8'hA5, 8'hA5, 3'd1};
    tbl[1] = '{1'b1, 8'h5A, 8'h5A, 3'd1};
    tbl[2] = '{1'b1, 8'hFF, 8'hFF, 3'd1};
    tbl[3] = '{1'b0, 8'h00, 8'h00, 3'd1};

    #1 reset = 1'b0;
    cyc();
    chk("rst_req_0", req_0, 0);
    chk("rst_req_1", req_1, 0);
    chk("rst_cnt0", cnt0, 0);
    chk("rst_cnt1", cnt1, 0);
    chk("rst_rdy0", in0_ready, 1);
    chk("rst_rdy1", in1_ready, 1);
    chk("rst_data0", data_in0, 0);
    reset = 1'b1;
    cyc();

    // Single-word latency vectors
    for (int i = 0; i < 4; i++) begin
      clear_logs();
      cyc();
      if (tbl[i].ch == 1'b0) begin in0_valid = 1'b1; in0_data = tbl[i].data; end
      else                   begin in1_valid = 1'b1; in1_data = tbl[i].data; end
      cyc();
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      chk("vec_cnt_t1", tbl[i].ch ? cnt1 : cnt0, tbl[i].exp_cnt_t1);
      chk("vec_req_t1", tbl[i].ch ? req_1 : req_0, 0);
      cyc();
      chk("vec_req_t2", tbl[i].ch ? req_1 : req_0, 1);
      chk("vec_head_t2", tbl[i].ch ? data_in1 : data_in0, tbl[i].data);
      cyc();
      chk("vec_arb_t3", arb_out, tbl[i].exp_arb);
      cyc();
      chk("vec_req_t4", tbl[i].ch ? req_1 : req_0, 0);
      chk("vec_cnt_t4", tbl[i].ch ? cnt1 : cnt0, 0);
      chk("vec_ndeliv", tbl[i].ch ? log1.size() : log0.size(), 1);
    end

    // Stale grant: grant_0 still held from the last ch0 retire
    clear_logs();
    cyc();
    in0_valid = 1'b1;
    in0_data  = 8'h3C;
    cyc();
    in0_valid = 1'b0;
    cyc();
    chk("stale_req_t2", req_0, 1);
    cyc();
    chk("stale_nopop_t3", cnt0, 1);
    cyc();
    chk("stale_pop_t4", cnt0, 0);
    chk("stale_req_t4", req_0, 0);
    for (int k = 0; k < 5; k++) cyc();
    chk("stale_once", log0.size(), 1);
    chk("stale_data", (log0.size() > 0) ? log0[0] : 8'hxx, 8'h3C);

    // Contention: four words per channel pushed back-to-back
    do_reset();
    cyc();
    for (int k = 0; k < 4; k++) begin
      in0_valid = 1'b1; in0_data = 8'h10 + DW'(k);
      in1_valid = 1'b1; in1_data = 8'h20 + DW'(k);
      cyc();
    end
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    for (int k = 0; k < 100 && order.size() < 8; k++) cyc();
    for (int k = 0; k < 4; k++) cyc();
    chk("cont_total", order.size(), 8);
    for (int k = 0; k < 4; k++) begin
      chk("cont_data0", (k < log0.size()) ? log0[k] : 8'hxx, 8'h10 + k);
      chk("cont_data1", (k < log1.size()) ? log1[k] : 8'hxx, 8'h20 + k);
    end
    for (int j = 0; j < 8; j++)
      chk("cont_alt", (j < order.size()) ? order[j] : -1, j % 2);
    chk("cont_cnt0", cnt0, 0);
    chk("cont_cnt1", cnt1, 0);
`ifdef ARBI_REQ_STATS_EN
    chk("stats_gnt0", gnt_cnt0, 4);
    chk("stats_gnt1", gnt_cnt1, 4);
    chk("stats_stall1_nz", stall_cnt1 != 16'd0, 1);
`endif

    // Full: grants blocked, five words offered on ch0
    clear_logs();
    force_zero = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in0_valid = 1'b1;
      in0_data  = 8'h40 + DW'(k);
      chk("full_rdy_pre", in0_ready, 1);
      cyc();
    end
    chk("full_rdy_low", in0_ready, 0);
    chk("full_cnt4", cnt0, 4);
    in0_data = 8'h44;
    for (int k = 0; k < 3; k++) cyc();
    chk("full_hold_cnt", cnt0, 4);
    chk("full_hold_rdy", in0_ready, 0);
    chk("full_head", data_in0, 8'h40);
    force_zero = 1'b0;
    for (int k = 0; k < 20 && !in0_ready; k++) cyc();
    chk("full_rdy_back", in0_ready, 1);
    chk("full_cnt3", cnt0, 3);
    chk("full_first_out", (log0.size() > 0) ? log0[0] : 8'hxx, 8'h40);
    cyc();
    in0_valid = 1'b0;
    chk("full_5th_in", cnt0, 4);
    for (int k = 0; k < 40 && log0.size() < 5; k++) cyc();
    chk("full_total", log0.size(), 5);
    for (int k = 0; k < 5; k++)
      chk("full_data", (k < log0.size()) ? log0[k] : 8'hxx, 8'h40 + k);

    // Reset mid-traffic
    clear_logs();
    cyc();
    in0_valid = 1'b1; in0_data = 8'h77;
    in1_valid = 1'b1; in1_data = 8'h88;
    cyc();
    in0_data = 8'h78;
    in1_data = 8'h89;
    cyc();
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    chk("mid_req0_pre", req_0, 1);
    #3 reset = 1'b0;
    #1;
    chk("mid_req0", req_0, 0);
    chk("mid_req1", req_1, 0);
    chk("mid_cnt0", cnt0, 0);
    chk("mid_cnt1", cnt1, 0);
    chk("mid_rdy0", in0_ready, 1);
    chk("mid_rdy1", in1_ready, 1);
    chk("mid_data1", data_in1, 0);
    cyc();
    reset = 1'b1;
    cyc();
    cyc();
    cyc();
    chk("mid_idle_req0", req_0, 0);
    chk("mid_idle_req1", req_1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
